// File: rtl/fifo_burst_rd_sched_if.sv
// Signal bundle between the burst read scheduler, its FIFO, the burst arbiter and the stream sink.
// "master" is the scheduler's view; "slave" is the view of the surrounding logic.
interface fifo_burst_rd_sched_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic [ADDR_WIDTH:0]   fifo_rd_water_level;
    logic                  flush;
    logic                  burst_req;
    logic [ADDR_WIDTH:0]   burst_len;
    logic                  burst_ack;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  busy;

    modport master (
        output fifo_rd_en, burst_req, burst_len, m_data, m_valid, m_last, busy,
        input  fifo_rd_data, fifo_empty, fifo_rd_water_level, flush, burst_ack, m_ready
    );

    modport slave (
        input  fifo_rd_en, burst_req, burst_len, m_data, m_valid, m_last, busy,
        output fifo_rd_data, fifo_empty, fifo_rd_water_level, flush, burst_ack, m_ready
    );
endinterface

// File: rtl/fifo_burst_rd_sched.sv
// Read-side burst scheduler: requests a burst from the FIFO level (full, flush or timeout)
// and drains exactly the granted word count through a 2-entry buffer onto a valid/ready stream.
module fifo_burst_rd_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_burst_rd_sched_if.master bus
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LW-1:0] BURST_LEN_V = LW'(BURST_LEN);
    localparam logic [IW-1:0] TIMEOUT_V   = IW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         burst_len_q, burst_len_d;
    logic [LW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [LW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic                  flush_pending_q, flush_pending_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            occ_q;
    logic                  inflight;
    logic                  rd_en, push, pop;
    logic [LW-1:0]         level;

    assign level = bus.fifo_rd_water_level;

    // Read credit uses only registered occupancy and in-flight reads, so the buffer can never overflow
    // even if the sink stalls on the very cycle the read data lands.
    assign rd_en = (state_q == S_XFER) && (issue_cnt_q != '0) && !bus.fifo_empty
                   && ((occ_q + {1'b0, inflight}) < 2'd2);
    assign pop   = (occ_q != 2'd0) && bus.m_ready;

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign inflight = 1'b0;
            assign push     = rd_en;
        end else begin : g_lat1
            logic inflight_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) inflight_q <= 1'b0;
                else     inflight_q <= rd_en;
            end
            assign inflight = inflight_q;
            assign push     = inflight_q;
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        burst_len_d     = burst_len_q;
        issue_cnt_d     = issue_cnt_q;
        beat_cnt_d      = beat_cnt_q;
        idle_cnt_d      = '0;
        flush_pending_d = flush_pending_q;

        if (bus.flush)
            flush_pending_d = 1'b1;
        else if (state_q == S_IDLE && level == '0)
            flush_pending_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (level != '0 && level < BURST_LEN_V)
                    idle_cnt_d = (idle_cnt_q == TIMEOUT_V) ? idle_cnt_q : idle_cnt_q + IW'(1);
                if (level >= BURST_LEN_V) begin
                    state_d     = S_REQ;
                    burst_len_d = BURST_LEN_V;
                    idle_cnt_d  = '0;
                end else if (level != '0 &&
                             (flush_pending_q || (TIMEOUT != 0 && idle_cnt_q == TIMEOUT_V))) begin
                    state_d     = S_REQ;
                    burst_len_d = level;
                    idle_cnt_d  = '0;
                end
            end
            S_REQ: begin
                if (bus.burst_ack) begin
                    state_d     = S_XFER;
                    issue_cnt_d = burst_len_q;
                    beat_cnt_d  = burst_len_q;
                end
            end
            S_XFER: begin
                if (rd_en) issue_cnt_d = issue_cnt_q - LW'(1);
                if (pop) begin
                    beat_cnt_d = beat_cnt_q - LW'(1);
                    if (beat_cnt_q == LW'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            burst_len_q     <= '0;
            issue_cnt_q     <= '0;
            beat_cnt_q      <= '0;
            idle_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_len_q     <= burst_len_d;
            issue_cnt_q     <= issue_cnt_d;
            beat_cnt_q      <= beat_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= bus.fifo_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.burst_req  = (state_q == S_REQ);
    assign bus.burst_len  = burst_len_q;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = buf_q[rd_ptr_q];
    assign bus.m_last     = (occ_q != 2'd0) && (beat_cnt_q == LW'(1));
    assign bus.busy       = (state_q != S_IDLE) || flush_pending_q;
endmodule
